// File: rtl/operand_fetch.sv
// operand_fetch: register file plus a 1-entry operand output register that
// feeds the shifter/ALU stage. A write port updates the registers every cycle,
// independent of the handshake. A fetch request reads two registers and
// latches them, together with a 2-bit shift code, behind a valid/ready
// output register.
//
// Optional feature macro: WRITE_BYPASS_EN
//   When it is defined, a write that lands in the same cycle as an accepted
//   request, and that targets rn_a or rn_b, forwards data_in into the
//   captured operand.
//   When it is undefined, the captured operand is the value the register held
//   before the write.
module operand_fetch #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int AW     = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  // writeback port
  input  logic              write,
  input  logic [AW-1:0]     writenum,
  input  logic [DATA_W-1:0] data_in,
  // fetch request
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [AW-1:0]     rn_a,
  input  logic [AW-1:0]     rn_b,
  input  logic [1:0]        shift_in,
  // operand set to the shifter stage
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [1:0]        shift_out
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] a_reg, a_next;
  logic [DATA_W-1:0] b_reg, b_next;
  logic [1:0]        shift_reg, shift_next;

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] rd_a, rd_b;
  logic [DATA_W-1:0] op_a, op_b;
  logic              accept, drain;

  // Register file. Every register is cleared by reset, so each one is built
  // as its own flop bank rather than as an inferred RAM. A writenum that is
  // out of range (possible only when NREGS is not a power of 2) matches no
  // bank, so that write is dropped.
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      logic [DATA_W-1:0] r_reg;
      logic              wr_en;

      assign wr_en = write && (writenum == AW'(gi));

      // One register: cleared by reset, loaded on a matching write.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_reg <= '0;
        end else if (wr_en) begin
          r_reg <= data_in;
        end
      end

      assign regs[gi] = r_reg;
    end
  endgenerate

  // Read both operand ports from the registered state. An out-of-range
  // register number reads as zero.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (rn_a == AW'(i)) rd_a = regs[i];
      if (rn_b == AW'(i)) rd_b = regs[i];
    end
  end

`ifdef WRITE_BYPASS_EN
  logic wr_in_range;
  assign wr_in_range = write && ({1'b0, writenum} < (AW+1)'(NREGS));

  // Forward the write data into an operand whose register is being written
  // in this same cycle.
  always_comb begin
    op_a = rd_a;
    op_b = rd_b;
    if (wr_in_range && (writenum == rn_a)) op_a = data_in;
    if (wr_in_range && (writenum == rn_b)) op_b = data_in;
  end
`else
  // No forwarding: operands are the values held before this cycle's write.
  assign op_a = rd_a;
  assign op_b = rd_b;
`endif

  // Handshake. A full output register can take a new set in the same cycle
  // that the downstream stage consumes the current one.
  assign out_valid = (state_reg == FULL);
  assign req_ready = ~out_valid | out_ready;
  assign accept    = req_valid & req_ready;
  assign drain     = out_valid & out_ready;

  // Next state and operand capture for the output register.
  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    shift_next = shift_reg;

    case (state_reg)
      EMPTY: begin
        if (accept) state_next = FULL;
      end
      FULL: begin
        if (drain && !accept) state_next = EMPTY;
      end
      default: state_next = EMPTY;
    endcase

    if (accept) begin
      a_next     = op_a;
      b_next     = op_b;
      shift_next = shift_in;
    end
  end

  // State and operand registers. Reset clears them at once, even in the
  // middle of a transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= EMPTY;
      a_reg     <= '0;
      b_reg     <= '0;
      shift_reg <= 2'b00;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      shift_reg <= shift_next;
    end
  end

  assign a_out     = a_reg;
  assign b_out     = b_reg;
  assign shift_out = shift_reg;

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed scenarios followed by random traffic. The
// results are checked against a reference model made of a register array and
// a queue that holds at most one operand set.
// Optional feature macro: WRITE_BYPASS_EN. It is honoured by the model and
// by the directed expectations.
module tb_operand_fetch;

  localparam int DATA_W = 16;
  localparam int NREGS  = 8;
  localparam int AW     = 3;

  logic              clk;
  logic              reset;
  logic              write;
  logic [AW-1:0]     writenum;
  logic [DATA_W-1:0] data_in;
  logic              req_valid;
  logic              req_ready;
  logic [AW-1:0]     rn_a;
  logic [AW-1:0]     rn_b;
  logic [1:0]        shift_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] a_out;
  logic [DATA_W-1:0] b_out;
  logic [1:0]        shift_out;

  operand_fetch #(.DATA_W(DATA_W), .NREGS(NREGS)) dut (
    .clk       (clk),
    .reset     (reset),
    .write     (write),
    .writenum  (writenum),
    .data_in   (data_in),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .rn_a      (rn_a),
    .rn_b      (rn_b),
    .shift_in  (shift_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_out     (a_out),
    .b_out     (b_out),
    .shift_out (shift_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: register contents and a queue of pending operand sets.
  typedef struct {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [1:0]        s;
  } opset_t;

  logic [DATA_W-1:0] m_regs [NREGS];
  opset_t            m_q [$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] m_read(input int rn, input bit w, input int wn,
                                               input logic [DATA_W-1:0] d);
`ifdef WRITE_BYPASS_EN
    if (w && wn == rn) return d;
`endif
    return m_regs[rn];
  endfunction

  task automatic m_clear();
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    m_q.delete();
  endtask

  // Runs one clock cycle. Inputs are driven after the falling edge, req_ready
  // is checked before the rising edge, and the outputs are checked 1 ns after
  // the rising edge.
  task automatic cycle(input bit w, input int wn, input logic [DATA_W-1:0] d,
                       input bit rv, input int ra, input int rb,
                       input logic [1:0] sh, input bit ordy);
    bit     exp_ready;
    bit     acc;
    bit     drn;
    opset_t ns;
    @(negedge clk);
    write     = w;
    writenum  = AW'(wn);
    data_in   = d;
    req_valid = rv;
    rn_a      = AW'(ra);
    rn_b      = AW'(rb);
    shift_in  = sh;
    out_ready = ordy;
    #1;
    exp_ready = (m_q.size() == 0) || ordy;
    check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
    acc = rv && exp_ready;
    drn = (m_q.size() != 0) && ordy;
    ns.a = m_read(ra, w, wn, d);
    ns.b = m_read(rb, w, wn, d);
    ns.s = sh;
    @(posedge clk);
    if (drn) void'(m_q.pop_front());
    if (acc) begin
      m_q.push_back(ns);
      n_txn++;
      $display("txn %0d: rn_a=%0d rn_b=%0d sh=%0d -> a=%h b=%h", n_txn, ra, rb, sh, ns.a, ns.b);
    end
    if (w && wn < NREGS) m_regs[wn] = d;
    #1;
    check_eq("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      check_eq("a_out", 32'(a_out), 32'(m_q[0].a));
      check_eq("b_out", 32'(b_out), 32'(m_q[0].b));
      check_eq("shift_out", 32'(shift_out), 32'(m_q[0].s));
    end
  endtask

  // Asserts reset in the middle of a cycle and checks that its effect is
  // immediate. Reset is released before the next clock edge.
  task automatic do_reset();
    #1;
    reset = 1'b1;
    #1;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_a", 32'(a_out), 32'd0);
    check_eq("rst_b", 32'(b_out), 32'd0);
    check_eq("rst_shift", 32'(shift_out), 32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    m_clear();
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [DATA_W-1:0] exp4;
    reset = 1'b1;
    write = 1'b0; writenum = '0; data_in = '0;
    req_valid = 1'b0; rn_a = '0; rn_b = '0; shift_in = '0; out_ready = 1'b0;
    m_clear();
    #12;
    check_eq("por_valid", 32'(out_valid), 32'd0);
    check_eq("por_b", 32'(b_out), 32'd0);
    reset = 1'b0;

    // Scenario 1: reset taken while the output register holds a valid set.
    cycle(1, 2, 16'hBEEF, 0, 0, 0, 2'b00, 0);
    cycle(0, 0, 16'h0000, 1, 2, 2, 2'b10, 0);
    check_eq("s1_full", 32'(out_valid), 32'd1);
    do_reset();

    // Scenario 2: write R3, then fetch it on both operand ports.
    cycle(1, 3, 16'hF0CF, 0, 0, 0, 2'b00, 1);
    cycle(0, 0, 16'h0000, 1, 3, 3, 2'b01, 1);
    check_eq("s2_valid", 32'(out_valid), 32'd1);
    check_eq("s2_a", 32'(a_out), 32'hF0CF);
    check_eq("s2_b", 32'(b_out), 32'hF0CF);
    check_eq("s2_shift", 32'(shift_out), 32'd1);

    // Scenario 3: stall for 5 cycles with a new request pending.
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 16'h0000, 1, 1, 0, 2'b10, 0);
      check_eq("s3_ready", 32'(req_ready), 32'd0);
      check_eq("s3_hold_b", 32'(b_out), 32'hF0CF);
    end
    cycle(0, 0, 16'h0000, 1, 1, 0, 2'b10, 1);
    check_eq("s3_new_b", 32'(b_out), 32'h0000);
    check_eq("s3_new_shift", 32'(shift_out), 32'd2);

    // Scenario 4: write and read the same register in one cycle.
    cycle(1, 5, 16'h0000, 0, 0, 0, 2'b00, 1);
    cycle(1, 5, 16'h1234, 1, 0, 5, 2'b00, 1);
`ifdef WRITE_BYPASS_EN
    exp4 = 16'h1234;
`else
    exp4 = 16'h0000;
`endif
    check_eq("s4_b_same", 32'(b_out), 32'(exp4));
    cycle(0, 0, 16'h0000, 1, 0, 5, 2'b00, 1);
    check_eq("s4_b_next", 32'(b_out), 32'h1234);

    // Scenario 5: back-to-back requests, one operand set per cycle.
    cycle(1, 1, 16'h0001, 0, 0, 0, 2'b00, 1);
    cycle(1, 2, 16'h0002, 0, 0, 0, 2'b00, 1);
    cycle(1, 3, 16'h0003, 0, 0, 0, 2'b00, 1);
    for (int i = 1; i <= 3; i++) begin
      cycle(0, 0, 16'h0000, 1, 0, i, 2'b00, 1);
      check_eq("s5_valid", 32'(out_valid), 32'd1);
      check_eq("s5_b", 32'(b_out), 32'(i));
    end

    // Scenario 6: one request, then a drain with no new request.
    cycle(1, 7, 16'h7000, 0, 0, 0, 2'b00, 1);
    cycle(0, 0, 16'h0000, 1, 0, 7, 2'b11, 1);
    check_eq("s6_shift", 32'(shift_out), 32'd3);
    check_eq("s6_b", 32'(b_out), 32'h7000);
    cycle(0, 0, 16'h0000, 0, 0, 0, 2'b00, 1);
    check_eq("s6_empty", 32'(out_valid), 32'd0);

    // Random traffic, with an occasional reset in the middle of a cycle.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(199) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(1), $urandom_range(NREGS-1), 16'($urandom),
              ($urandom_range(9) < 7), $urandom_range(NREGS-1), $urandom_range(NREGS-1),
              2'($urandom), ($urandom_range(9) < 6));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
